// File: rtl/emtf_axi_pkg.sv
// rtl/emtf_axi_pkg.sv - shared constants, FSM states and helpers for the EMTF AXI4 memory slave
package emtf_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_DATA
    } state_t;

    // Ceiling log2, used to turn the strobe width into a byte-offset shift.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/emtf_axi_burst_addr.sv
// rtl/emtf_axi_burst_addr.sv - next-beat address, beat error check and word-address conversion
module emtf_axi_burst_addr
    import emtf_axi_pkg::*;
#(
    parameter int              DW        = 64,
    parameter int              AW        = 32,
    parameter int              MEM_AW    = 12,
    parameter logic [AW-1:0]   BASE_ADDR = '0
) (
    input  logic [AW-1:0]      i_addr,
    input  logic [2:0]         i_size,
    input  logic [1:0]         i_burst,
    output logic [AW-1:0]      o_next_addr,
    output logic [MEM_AW-1:0]  o_word_addr,
    output logic               o_beat_err
);

    localparam int LG     = clog2(DW / 8);
    localparam int WIN_LG = MEM_AW + LG;

    logic [AW-1:0] w_offset;
    logic [AW-1:0] w_step;
    logic          w_size_err;
    logic          w_burst_err;
    logic          w_range_err;

    assign w_offset    = i_addr - BASE_ADDR;
    assign w_step      = AW'(1) << i_size;

    // Any offset bit at or above the window size means the beat falls past the window end.
    assign w_range_err = (i_addr < BASE_ADDR) || ((w_offset >> WIN_LG) != '0);
    assign w_size_err  = (i_size > 3'(LG));
    assign w_burst_err = (i_burst == BURST_WRAP) || (i_burst == 2'b11);

    assign o_beat_err  = w_range_err || w_size_err || w_burst_err;
    assign o_next_addr = (i_burst == BURST_FIXED) ? i_addr : (i_addr + w_step);
    assign o_word_addr = w_offset[LG +: MEM_AW];

endmodule

// File: rtl/emtf_axi_mem_slave.sv
// rtl/emtf_axi_mem_slave.sv - AXI4 slave endpoint driving a single-port word-addressed memory window
module emtf_axi_mem_slave
    import emtf_axi_pkg::*;
#(
    parameter int              DW        = 64,
    parameter int              IDW       = 6,
    parameter int              AW        = 32,
    parameter int              MEM_AW    = 12,
    parameter logic [AW-1:0]   BASE_ADDR = '0
) (
    input  logic               s_aclk,
    input  logic               s_aresetn,
    input  logic [IDW-1:0]     awid,
    input  logic [AW-1:0]      awaddr,
    input  logic [7:0]         awlen,
    input  logic [2:0]         awsize,
    input  logic [1:0]         awburst,
    input  logic               awvalid,
    output logic               awready,
    input  logic [DW-1:0]      wdata,
    input  logic [DW/8-1:0]    wstrb,
    input  logic               wlast,
    input  logic               wvalid,
    output logic               wready,
    output logic [IDW-1:0]     bid,
    output logic [1:0]         bresp,
    output logic               bvalid,
    input  logic               bready,
    input  logic [IDW-1:0]     arid,
    input  logic [AW-1:0]      araddr,
    input  logic [7:0]         arlen,
    input  logic [2:0]         arsize,
    input  logic [1:0]         arburst,
    input  logic               arvalid,
    output logic               arready,
    output logic [IDW-1:0]     rid,
    output logic [DW-1:0]      rdata,
    output logic [1:0]         rresp,
    output logic               rlast,
    output logic               rvalid,
    input  logic               rready,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic               mem_we,
    output logic [DW/8-1:0]    mem_be,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata
);

    state_t            r_state;
    state_t            w_next;
    logic [IDW-1:0]    r_id;
    logic [AW-1:0]     r_addr;
    logic [7:0]        r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_err;
    logic              r_rr_rd;
    logic [DW-1:0]     r_rdata;
    logic              r_rresp_err;

    logic [AW-1:0]     w_next_addr;
    logic [MEM_AW-1:0] w_word_addr;
    logic              w_beat_err;
    logic              w_grant_wr;
    logic              w_grant_rd;
    logic              w_last;
    logic              w_wr_beat;

    emtf_axi_burst_addr #(
        .DW        (DW),
        .AW        (AW),
        .MEM_AW    (MEM_AW),
        .BASE_ADDR (BASE_ADDR)
    ) u_burst_addr (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr),
        .o_word_addr (w_word_addr),
        .o_beat_err  (w_beat_err)
    );

    // Round-robin only matters under contention: r_rr_rd=0 favours the write channel.
    assign w_grant_wr = awvalid && (!arvalid || !r_rr_rd);
    assign w_grant_rd = arvalid && (!awvalid || r_rr_rd);
    assign w_last     = (r_cnt == 8'd0);
    assign w_wr_beat  = (r_state == ST_WR_DATA) && wvalid;

    assign mem_addr   = w_word_addr;
    assign mem_we     = w_wr_beat && !w_beat_err;
    assign mem_be     = mem_we ? wstrb : '0;
    assign mem_wdata  = mem_we ? wdata : '0;

    assign bid        = r_id;
    assign bresp      = r_err ? RESP_SLVERR : RESP_OKAY;
    assign rid        = r_id;
    assign rdata      = r_rdata;
    assign rresp      = r_rresp_err ? RESP_SLVERR : RESP_OKAY;
    assign rlast      = (r_state == ST_RD_DATA) && w_last;

    // State register; reset abandons any burst in progress without a response.
    always_ff @(posedge s_aclk) begin
        if (!s_aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and channel handshake signals.
    always_comb begin
        w_next  = r_state;
        awready = 1'b0;
        arready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_aresetn && w_grant_wr) begin
                    awready = 1'b1;
                    w_next  = ST_WR_DATA;
                end else if (s_aresetn && w_grant_rd) begin
                    arready = 1'b1;
                    w_next  = ST_RD_ISSUE;
                end
            end
            ST_WR_DATA: begin
                wready = 1'b1;
                if (wvalid && w_last) begin
                    w_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_next = ST_IDLE;
                end
            end
            ST_RD_ISSUE: w_next = ST_RD_WAIT;
            ST_RD_WAIT:  w_next = ST_RD_DATA;
            ST_RD_DATA: begin
                rvalid = 1'b1;
                if (rready) begin
                    w_next = w_last ? ST_IDLE : ST_RD_ISSUE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Burst context: capture on grant, step per beat, accumulate errors, latch read data.
    always_ff @(posedge s_aclk) begin
        if (!s_aresetn) begin
            r_id        <= '0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_err       <= 1'b0;
            r_rr_rd     <= 1'b0;
            r_rdata     <= '0;
            r_rresp_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_wr || w_grant_rd) begin
                        r_id    <= w_grant_wr ? awid    : arid;
                        r_addr  <= w_grant_wr ? awaddr  : araddr;
                        r_cnt   <= w_grant_wr ? awlen   : arlen;
                        r_size  <= w_grant_wr ? awsize  : arsize;
                        r_burst <= w_grant_wr ? awburst : arburst;
                        r_err   <= 1'b0;
                        if (awvalid && arvalid) begin
                            r_rr_rd <= !r_rr_rd;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (wvalid) begin
                        // The beat count ends the burst; a misplaced wlast only poisons the response.
                        if (w_beat_err || (wlast != w_last)) begin
                            r_err <= 1'b1;
                        end
                        if (!w_last) begin
                            r_cnt  <= r_cnt - 8'd1;
                            r_addr <= w_next_addr;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    r_rdata     <= w_beat_err ? '0 : mem_rdata;
                    r_rresp_err <= w_beat_err;
                end
                ST_RD_DATA: begin
                    if (rready && !w_last) begin
                        r_cnt  <= r_cnt - 8'd1;
                        r_addr <= w_next_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_emtf_axi_mem_slave.sv
// tb/tb_emtf_axi_mem_slave.sv - scoreboard bench for emtf_axi_mem_slave
module tb_emtf_axi_mem_slave;
    import emtf_axi_pkg::*;

    localparam int DW     = 64;
    localparam int IDW    = 6;
    localparam int AW     = 32;
    localparam int MEM_AW = 12;

    logic              s_aclk = 1'b0;
    logic              s_aresetn;
    logic [IDW-1:0]    awid;
    logic [AW-1:0]     awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [IDW-1:0]    bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [IDW-1:0]    arid;
    logic [AW-1:0]     araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [IDW-1:0]    rid;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [DW/8-1:0]   mem_be;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    emtf_axi_mem_slave #(
        .DW(DW), .IDW(IDW), .AW(AW), .MEM_AW(MEM_AW), .BASE_ADDR(32'h0)
    ) dut (
        .s_aclk(s_aclk), .s_aresetn(s_aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 s_aclk = ~s_aclk;

    typedef struct packed { logic [MEM_AW-1:0] addr; logic [7:0] be; logic [DW-1:0] data; } mw_t;
    typedef struct packed { logic [IDW-1:0] id; logic [1:0] resp; } b_t;
    typedef struct packed { logic [IDW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_t;

    mw_t  mw_q[$];
    b_t   b_q[$];
    r_t   r_q[$];
    logic g_q[$];
    mw_t  m_mw;
    b_t   m_b;
    r_t   m_r;
    logic m_g;

    int      n_checks = 0;
    int      n_fail = 0;
    int      b_done = 0;
    int      r_done = 0;
    int      rready_mode = 1;
    bit      g_chk = 1'b0;
    bit      r_stall = 1'b0;
    logic [DW-1:0] r_stall_data;

    logic [DW-1:0] mem [0:(1<<MEM_AW)-1];
    logic          mem_init_done = 1'b0;

    // Memory model: one-cycle read latency, byte-enabled writes, preload on first clock.
    always @(posedge s_aclk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < (1 << MEM_AW); i++) begin
                mem[i] <= (i < 4) ? (DW'(32'h100) + DW'(i)) : '0;
            end
            mem_init_done <= 1'b1;
        end else if (mem_we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        mem_rdata <= mem[mem_addr];
    end

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void exp_mw(input logic [MEM_AW-1:0] a, input logic [7:0] be, input logic [DW-1:0] d);
        mw_t e;
        e.addr = a; e.be = be; e.data = d;
        mw_q.push_back(e);
    endfunction

    function automatic void exp_b(input logic [IDW-1:0] id, input logic [1:0] resp);
        b_t e;
        e.id = id; e.resp = resp;
        b_q.push_back(e);
    endfunction

    function automatic void exp_r(input logic [IDW-1:0] id, input logic [DW-1:0] d, input logic [1:0] resp, input logic last);
        r_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        r_q.push_back(e);
    endfunction

    // rready pattern: 0 = held low, 1 = held high, otherwise random stalls.
    initial begin
        rready = 1'b0;
        forever begin
            @(posedge s_aclk);
            #1;
            case (rready_mode)
                0:       rready = 1'b0;
                1:       rready = 1'b1;
                default: rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops and compares on every memory write, B handshake, R handshake and grant.
    always @(negedge s_aclk) begin
        if (!s_aresetn) begin
            r_stall = 1'b0;
        end else begin
            if (mem_we) begin
                if (mw_q.size() == 0) begin
                    check("mem_we_unexpected", mem_we, 1'b0);
                end else begin
                    m_mw = mw_q.pop_front();
                    check("mem_addr", mem_addr, m_mw.addr);
                    check("mem_be", mem_be, m_mw.be);
                    check("mem_wdata", mem_wdata, m_mw.data);
                end
            end
            if (bvalid && bready) begin
                if (b_q.size() == 0) begin
                    check("bvalid_unexpected", bvalid, 1'b0);
                end else begin
                    m_b = b_q.pop_front();
                    check("bid", bid, m_b.id);
                    check("bresp", bresp, m_b.resp);
                end
                b_done++;
            end
            if (r_stall && rvalid) check("rdata_stable", rdata, r_stall_data);
            r_stall      = rvalid && !rready;
            r_stall_data = rdata;
            if (rvalid && rready) begin
                if (r_q.size() == 0) begin
                    check("rvalid_unexpected", rvalid, 1'b0);
                end else begin
                    m_r = r_q.pop_front();
                    check("rid", rid, m_r.id);
                    check("rdata", rdata, m_r.data);
                    check("rresp", rresp, m_r.resp);
                    check("rlast", rlast, m_r.last);
                end
                if (rlast) r_done++;
            end
            if (g_chk && ((awvalid && awready) || (arvalid && arready))) begin
                if (g_q.size() == 0) begin
                    check("grant_unexpected", awready | arready, 1'b0);
                end else begin
                    m_g = g_q.pop_front();
                    check("grant_is_read", arready, m_g);
                end
            end
        end
    end

    task automatic aw_send(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge s_aclk);
            if (awready) break;
        end
        if (!awready) check("aw_timeout", awready, 1'b1);
        @(posedge s_aclk);
        #1 awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge s_aclk);
            if (arready) break;
        end
        if (!arready) check("ar_timeout", arready, 1'b1);
        @(posedge s_aclk);
        #1 arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [DW-1:0] data0, input logic [7:0] strb,
                            input int early, input bit chk_lat);
        int b0;
        b0 = b_done;
        aw_send(id, addr, len, 3'd3, burst);
        for (int k = 0; k <= int'(len); k++) begin
            wdata  = data0 + DW'(k);
            wstrb  = strb;
            wlast  = (early >= 0) ? (k == early) : (k == int'(len));
            wvalid = 1'b1;
            for (int t = 0; t < 300; t++) begin
                @(negedge s_aclk);
                if (wready) break;
            end
            if (!wready) check("w_timeout", wready, 1'b1);
            @(posedge s_aclk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        if (chk_lat) begin
            @(negedge s_aclk);
            check("b_latency", bvalid, 1'b1);
        end
        for (int t = 0; t < 300; t++) begin
            if (b_done != b0) break;
            @(negedge s_aclk);
        end
        check("b_done", b_done - b0, 1);
        @(posedge s_aclk);
        #1;
    endtask

    task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input bit chk_lat);
        int r0;
        int n;
        r0 = r_done;
        ar_send(id, addr, len, 3'd3, BURST_INCR);
        if (chk_lat) begin
            n = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge s_aclk);
                n++;
                if (rvalid) break;
            end
            check("r_latency", n, 3);
        end
        for (int t = 0; t < 3000; t++) begin
            if (r_done != r0) break;
            @(negedge s_aclk);
        end
        check("r_done", r_done - r0, 1);
        @(posedge s_aclk);
        #1;
    endtask

    initial begin
        s_aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b1;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b1; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b1;
        repeat (4) @(posedge s_aclk);
        #1;
        check("rst_awready", awready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_rdata", rdata, 64'h0);
        check("rst_bid", bid, 6'h0);
        check("rst_bresp", bresp, 2'b00);
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
        s_aresetn = 1'b1;
        repeat (2) @(posedge s_aclk);
        #1;

        // Contention rounds: write wins first, then the winner alternates.
        g_chk = 1'b1;
        g_q.push_back(1'b0); g_q.push_back(1'b1);
        g_q.push_back(1'b1); g_q.push_back(1'b0);
        g_q.push_back(1'b0); g_q.push_back(1'b1);
        for (int k = 0; k < 3; k++) begin
            exp_mw(12'h20 + 12'(k), 8'hFF, 64'hA0A0_0000_0000_0000 + 64'(k));
            exp_b(6'(k + 1), RESP_OKAY);
            exp_r(6'(k + 16), 64'h101 + 64'(k), RESP_OKAY, 1'b1);
            fork
                do_write(6'(k + 1), 32'h100 + 32'(8 * k), 8'd0, BURST_INCR,
                         64'hA0A0_0000_0000_0000 + 64'(k), 8'hFF, -1, 1'b0);
                do_read(6'(k + 16), 32'h8 + 32'(8 * k), 8'd0, 1'b0);
            join
        end
        g_chk = 1'b0;
        check("grant_q_empty", g_q.size(), 0);

        // INCR read of the preloaded words under random rready stalls.
        rready_mode = 2;
        for (int i = 0; i < 4; i++) exp_r(6'h05, 64'h100 + 64'(i), RESP_OKAY, i == 3);
        do_read(6'h05, 32'h0, 8'd3, 1'b1);
        rready_mode = 1;

        // Single partial-strobe write.
        exp_mw(12'd2, 8'h0F, 64'h1122334455667788);
        exp_b(6'h2A, RESP_OKAY);
        do_write(6'h2A, 32'h10, 8'd0, BURST_INCR, 64'h1122334455667788, 8'h0F, -1, 1'b1);

        // FIXED burst hits one word three times; the last beat persists.
        for (int k = 0; k < 3; k++) exp_mw(12'd1, 8'hFF, 64'hF00D_0000_0000_0000 + 64'(k));
        exp_b(6'h03, RESP_OKAY);
        do_write(6'h03, 32'h8, 8'd2, BURST_FIXED, 64'hF00D_0000_0000_0000, 8'hFF, -1, 1'b0);
        exp_r(6'h04, 64'hF00D_0000_0000_0002, RESP_OKAY, 1'b1);
        do_read(6'h04, 32'h8, 8'd0, 1'b0);

        // WRAP burst: all beats consumed, nothing written, SLVERR.
        exp_b(6'h06, RESP_SLVERR);
        do_write(6'h06, 32'h40, 8'd3, BURST_WRAP, 64'h5555, 8'hFF, -1, 1'b0);

        // Read starting past the window end.
        exp_r(6'h07, 64'h0, RESP_SLVERR, 1'b0);
        exp_r(6'h07, 64'h0, RESP_SLVERR, 1'b1);
        do_read(6'h07, 32'h8000, 8'd1, 1'b0);

        // Read crossing the window end: last in-window word is fine, next beat errors.
        exp_r(6'h09, 64'h0, RESP_OKAY, 1'b0);
        exp_r(6'h09, 64'h0, RESP_SLVERR, 1'b1);
        do_read(6'h09, 32'h7FF8, 8'd1, 1'b0);

        // Early wlast on beat 1 of a 4-beat burst.
        for (int k = 0; k < 4; k++) exp_mw(12'h20 + 12'(k), 8'hFF, 64'hBEEF_0000_0000_0000 + 64'(k));
        exp_b(6'h08, RESP_SLVERR);
        do_write(6'h08, 32'h100, 8'd3, BURST_INCR, 64'hBEEF_0000_0000_0000, 8'hFF, 1, 1'b0);

        // Reset while a read beat is presented, then a clean read.
        rready_mode = 0;
        repeat (2) @(posedge s_aclk);
        #1;
        ar_send(6'h11, 32'h0, 8'd3, 3'd3, BURST_INCR);
        for (int t = 0; t < 20; t++) begin
            @(negedge s_aclk);
            if (rvalid) break;
        end
        check("abort_rvalid_seen", rvalid, 1'b1);
        s_aresetn = 1'b0;
        @(posedge s_aclk);
        #1;
        check("abort_rvalid", rvalid, 1'b0);
        check("abort_rdata", rdata, 64'h0);
        check("abort_rlast", rlast, 1'b0);
        s_aresetn = 1'b1;
        rready_mode = 1;
        repeat (2) @(posedge s_aclk);
        #1;
        exp_r(6'h12, 64'h103, RESP_OKAY, 1'b1);
        do_read(6'h12, 32'h18, 8'd0, 1'b1);

        repeat (4) @(posedge s_aclk);
        check("mw_q_empty", mw_q.size(), 0);
        check("b_q_empty", b_q.size(), 0);
        check("r_q_empty", r_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
